// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family.
//   state_t   : FSM encoding (ST_IDLE = 0, ST_GRANT = 1)
//   cnt_width : width of a hold counter able to reach max_hold (minimum 1 bit)
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Holds values 0..max_hold. max_hold = 0 still gets one bit so the
  // counter declaration stays legal when the hold limit is disabled.
  function automatic int cnt_width(input int max_hold);
    int w;
    w = $clog2(max_hold + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-priority picker.
// Finds the first set bit of req searching ptr, ptr+1, ... wrapping modulo
// NUM_REQ.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   found : some bit of req is set
//   idx   : index of the winning request (0 when found = 0)
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  logic [2*NUM_REQ-1:0] dbl;

  // Duplicating the vector turns the wrap-around search into a plain
  // priority encode starting at ptr; a hit in the upper copy maps back
  // by subtracting NUM_REQ.
  always_comb begin
    dbl   = {req, req};
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < 2 * NUM_REQ; i++) begin
      if (!found && (i >= int'(ptr)) && dbl[i]) begin
        found = 1'b1;
        if (i >= NUM_REQ) idx = ID_W'(i - NUM_REQ);
        else              idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with registered one-hot grant, grant hold and an
// optional hold limit.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   req       : request vector, bit i high while requester i wants the resource
//   gnt       : registered one-hot grant, zero when idle
//   gnt_valid : |gnt
//   gnt_id    : index of the owner; holds its last value while idle
//   timeout   : one-cycle pulse when the hold limit revokes a grant
//   state     : current FSM state (debug visibility)
//
// Handshake: req[i] is a level request held by the master; gnt[i] is the
// answer. A grant is kept while req of the owner stays high (bounded by
// MAX_HOLD when non-zero); the owner releases by dropping req. Every tenure
// is followed by exactly one idle cycle with gnt = 0.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int MAX_HOLD = 16,
  parameter int ID_W     = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_valid,
  output logic [ID_W-1:0]    gnt_id,
  output logic               timeout,
  output state_t             state
);

  localparam int              CNT_W    = cnt_width(MAX_HOLD);
  localparam logic [CNT_W-1:0] HOLD_LIM = CNT_W'(MAX_HOLD);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  state_t             state_n;
  logic [ID_W-1:0]    ptr, ptr_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [NUM_REQ-1:0] gnt_n;
  logic               gnt_valid_n;
  logic [ID_W-1:0]    gnt_id_n;
  logic               timeout_n;

  logic               pick_found;
  logic [ID_W-1:0]    pick_idx;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req   (req),
    .ptr   (ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_valid <= 1'b0;
      gnt_id    <= '0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      cnt       <= cnt_n;
      gnt       <= gnt_n;
      gnt_valid <= gnt_valid_n;
      gnt_id    <= gnt_id_n;
      timeout   <= timeout_n;
    end
  end

  always_comb begin
    state_n     = state;
    ptr_n       = ptr;
    cnt_n       = cnt;
    gnt_n       = gnt;
    gnt_valid_n = gnt_valid;
    gnt_id_n    = gnt_id;
    timeout_n   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          gnt_n           = '0;
          gnt_n[pick_idx] = 1'b1;
          gnt_valid_n     = 1'b1;
          gnt_id_n        = pick_idx;
          cnt_n           = CNT_W'(1);
          state_n         = ST_GRANT;
        end
      end

      ST_GRANT: begin
        if (req[gnt_id] && ((MAX_HOLD == 0) || (cnt < HOLD_LIM))) begin
          // With no limit the counter only serves as a tenure length and
          // saturates instead of wrapping.
          if (cnt != '1) cnt_n = cnt + 1'b1;
        end else begin
          // Released or revoked: the owner moves to the back of the queue.
          // Explicit wrap because NUM_REQ need not be a power of two.
          gnt_n       = '0;
          gnt_valid_n = 1'b0;
          state_n     = ST_IDLE;
          ptr_n       = (gnt_id == LAST_ID) ? '0 : gnt_id + 1'b1;
          timeout_n   = req[gnt_id];
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
- Round-robin arbiter sharing one resource among NUM_REQ requesters.
- Follow-on to the two-requester fixed-priority arbiter. Adds fairness, a registered one-hot grant, grant hold while the request stays asserted, and forced release after a configurable hold limit.
- Sits between the requesting masters and the shared resource's select/mux logic.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- MAX_HOLD, 16, maximum consecutive grant cycles per tenure; 0 disables the limit.
- ID_W, $clog2(NUM_REQ), width of the encoded grant index (derived; do not override).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- req  input  NUM_REQ  request vector; bit i held high while requester i wants the resource.
- gnt  output  NUM_REQ  registered one-hot grant; all zero when idle.
- gnt_valid  output  1  high when any gnt bit is set.
- gnt_id  output  ID_W  index of the granted requester; holds its last value when gnt_valid=0.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. Assertion of reset_n=0 immediately forces:
  - gnt=0, gnt_valid=0, gnt_id=0, timeout=0;
  - priority pointer ptr=0, hold counter=0, state=IDLE.
  - Reset mid-tenure drops the grant at once. After release, arbitration restarts with ptr=0.
- States: IDLE and GRANT. All outputs are registered.
- IDLE:
  - If req!=0, pick the first set bit searching ptr, ptr+1, ..., wrapping modulo NUM_REQ.
  - At the next edge: gnt[k]=1, gnt_id=k, gnt_valid=1, hold counter=1, state=GRANT.
  - Latency is req rising to gnt rising in 1 cycle.
  - If req==0, stay in IDLE; ptr is unchanged.
- GRANT, owner k:
  - If req[k]=1 and (MAX_HOLD==0 or hold counter<MAX_HOLD): keep gnt and increment the counter. The counter saturates and never wraps when MAX_HOLD=0.
  - If req[k]=0: at the next edge gnt=0, state=IDLE, ptr=(k+1) mod NUM_REQ, timeout stays 0.
  - If req[k]=1 and hold counter==MAX_HOLD (MAX_HOLD>0): at the next edge gnt=0, timeout=1 for exactly one cycle, state=IDLE, ptr=(k+1) mod NUM_REQ.
  - The revoked requester may re-request and is served again only after the others have had their turn.
- Turnaround:
  - Every tenure ends with exactly one IDLE cycle with gnt=0 before the next grant.
  - Minimum spacing is therefore grant, idle, grant.
  - Maximum consecutive gnt cycles for one owner equals MAX_HOLD.
- Other requests during GRANT are ignored and do not preempt the owner.
- Simultaneous requests in IDLE are resolved solely by ptr order; there is no fixed priority.
- A request pulse that drops before being sampled in IDLE is never granted.
- With a single persistent requester:
  - MAX_HOLD>0: grant MAX_HOLD cycles, one idle cycle, then grant again.
  - MAX_HOLD=0: grant held indefinitely.
- Invariants: gnt is always zero or one-hot; gnt_valid == |gnt; timeout implies gnt==0 in the same cycle.
- Hold counter width is $clog2(MAX_HOLD+1), minimum 1 bit. Pointer width is ID_W; the wrap uses an explicit compare against NUM_REQ-1, not natural overflow, since NUM_REQ need not be a power of two.

Decomposition:
- Shared package arb_pkg: state encoding constants (ST_IDLE=1'b0, ST_GRANT=1'b1) and a function computing the counter width from MAX_HOLD.
- One sub-module rr_pick: combinational rotate-priority picker taking req and ptr, returning found and idx.
  - Implemented as a double-width request vector, priority encode, then subtract.
  - Reusable by future schedulers.
- Top rr_arbiter holds the FSM, ptr, hold counter and output registers.

Test Plan (NUM_REQ=4, MAX_HOLD=8):
1. Reset mid-grant: grant req=4'b0001, then pull reset_n low mid-cycle -> gnt=0, gnt_valid=0, timeout=0 immediately, without waiting for a clock edge. Release reset, then req=4'b0100 -> gnt=4'b0100 one cycle after the first edge.
2. Round-robin fairness: req=4'b1111 held continuously, each owner drops its req 3 cycles after its grant then reasserts it -> grant order 0,1,2,3,0, with exactly one idle cycle between tenures.
3. Hold limit: req=4'b0010 only, held high -> gnt=4'b0010 for exactly 8 cycles; then gnt=0 with timeout=1 for 1 cycle; gnt returns on the following cycle; pattern repeats.
4. Timeout fairness: req=4'b0011 both held -> owner 0 gets 8 cycles, timeout pulse, owner 1 gets 8 cycles, timeout pulse, then owner 0.
5. Non-preemption and wrap: owner 3 granted, req[0] asserted mid-tenure -> gnt stays 4'b1000. Owner 3 releases, one idle cycle, then gnt=4'b0001, gnt_id=0 (ptr wraps 3->0).
6. Short pulse: from idle, req[2] high for one cycle only -> gnt=4'b0100 for one cycle, then released with no timeout. A req pulse that is not high at a sampling edge -> no grant.
